// File: rtl/mem_arbiter.sv
// Two-requester refill arbiter: grants the icache or the dcache the shared memory port and
// sequences one LINE_WORDS burst. Define MEM_ARB_RR_EN for round-robin, else dcache has priority.
module mem_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_rvalid,
    output logic              i_rlast,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_wready,
    output logic [31:0]       d_rdata,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    output logic [31:0]       m_wdata,
    output logic              m_wvalid,
    output logic              m_wlast,
    input  logic              m_wready,
    output logic [1:0]        grant,
    output logic              err
);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_I    = 2'b01;
    localparam logic [1:0] G_D    = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, RDATA, WDATA} state_e;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       pick;
    logic             last_beat;

    assign last_beat = (cnt_q == LAST_BEAT);

`ifdef MEM_ARB_RR_EN
    // pref_i_q set means the icache wins a tie; it flips toward whoever was not granted last.
    logic pref_i_q, pref_i_d;

    assign pick = (i_req && (!d_req || pref_i_q)) ? G_I : G_D;

    always_comb begin
        pref_i_d = pref_i_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            pref_i_d = (pick == G_D);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            pref_i_q <= 1'b1;
        end else begin
            pref_i_q <= pref_i_d;
        end
    end
`else
    assign pick = d_req ? G_D : G_I;
`endif

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            grant_q <= G_NONE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                grant_d = G_NONE;
                cnt_d   = '0;
                if (i_req || d_req) begin
                    state_d = ADDR;
                    grant_d = pick;
                end
            end
            ADDR: begin
                cnt_d = '0;
                if (m_ready) begin
                    state_d = (grant_q == G_D && d_we) ? WDATA : RDATA;
                end
            end
            RDATA: begin
                if (m_rvalid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (m_rlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = IDLE;
                        grant_d = G_NONE;
                    end
                end
            end
            WDATA: begin
                if (m_wready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = IDLE;
                        grant_d = G_NONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read beats reach a side only while it still holds its request; a dropped burst drains silently.
    always_comb begin
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wvalid = 1'b0;
        m_wlast  = 1'b0;
        i_rdata  = '0;
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        d_rdata  = '0;
        d_rvalid = 1'b0;
        d_rlast  = 1'b0;
        d_wready = 1'b0;
        case (state_q)
            ADDR: begin
                m_req  = 1'b1;
                m_we   = (grant_q == G_D) && d_we;
                m_addr = (grant_q == G_D) ? d_addr : i_addr;
            end
            RDATA: begin
                if (grant_q == G_I) begin
                    i_rdata  = m_rdata;
                    i_rvalid = m_rvalid && i_req;
                    i_rlast  = m_rvalid && i_req && last_beat;
                end else begin
                    d_rdata  = m_rdata;
                    d_rvalid = m_rvalid && d_req;
                    d_rlast  = m_rvalid && d_req && last_beat;
                end
            end
            WDATA: begin
                m_wdata  = d_wdata;
                m_wvalid = 1'b1;
                m_wlast  = last_beat;
                d_rlast  = last_beat;
                d_wready = m_wready;
            end
            default: ;
        endcase
    end

    assign grant = grant_q;
    assign err   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven on the falling edge, outputs checked 1ns later
// against scoreboard queues filled as each memory beat is driven.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata, m_rdata, m_wdata;
    logic        i_rvalid, i_rlast, d_wready, d_rvalid, d_rlast;
    logic        m_req, m_we, m_ready, m_rvalid, m_rlast, m_wvalid, m_wlast, m_wready;
    logic [31:0] m_addr;
    logic [1:0]  grant;
    logic        err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          side;
        logic [31:0] data;
        logic        last;
    } rd_exp_t;
    rd_exp_t     rq[$];
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_ready(m_ready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
        .grant(grant), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Waits for the address phase, checks it, then accepts it.
    task automatic wait_addr(input logic [1:0] g, input logic [31:0] a, input logic we);
        int n = 0;
        do begin
            tick;
            #1;
            n++;
        end while (m_req !== 1'b1 && n < 10);
        chk("addr_latency", 64'(n), 64'd1);
        chk("grant", grant, g);
        chk("m_addr", m_addr, a);
        chk("m_we", m_we, we);
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
    endtask

    task automatic read_beat(input logic [31:0] data, input logic rl, input int side, input logic last);
        rd_exp_t e;
        m_rdata  = data;
        m_rlast  = rl;
        m_rvalid = 1'b1;
        rq.push_back('{side, data, last});
        #1;
        e = rq.pop_front();
        chk("i_rvalid", i_rvalid, e.side == 1);
        chk("d_rvalid", d_rvalid, e.side == 2);
        if (e.side == 1) begin
            chk("i_rdata", i_rdata, e.data);
            chk("i_rlast", i_rlast, e.last);
        end else if (e.side == 2) begin
            chk("d_rdata", d_rdata, e.data);
            chk("d_rlast", d_rlast, e.last);
        end else begin
            chk("rlast_suppressed", {i_rlast, d_rlast}, 2'b00);
        end
        tick;
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic rd_burst(input int side, input logic [31:0] base, input int bad_beat);
        for (int k = 0; k < 4; k++) begin
            read_beat(base + 32'(k), (k == 3) || (k == bad_beat), side, k == 3);
        end
        #1;
        chk("idle_grant", grant, 2'b00);
        chk("idle_m_req", m_req, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int     pulses;
        int     acc;
        logic   first_i;
        logic   p;
        logic [4:0] wr_pat;

        rstn = 1'b1; i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        m_ready = 0; m_rdata = 0; m_rvalid = 0; m_rlast = 0; m_wready = 0;
        tick; tick;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_outs", {i_rvalid, d_rvalid, m_wvalid, d_wready, i_rlast, d_rlast, m_wlast}, 7'd0);
        chk("rst_data", {m_addr, m_wdata}, 64'd0);
        tick;
        rstn = 1'b0;

        // icache refill
        i_req = 1'b1; i_addr = 32'h100;
        wait_addr(2'b01, 32'h100, 1'b0);
        rd_burst(1, 32'hA0, -1);
        i_req = 1'b0;
        chk("icache_err", err, 1'b0);

        // dcache write-back with stalls
        tick;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hD0;
        wait_addr(2'b10, 32'h200, 1'b1);
        wr_pat = 5'b11101;
        pulses = 0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            p = wr_pat[c];
            m_wready = p;
            d_wdata = 32'hD0 + 32'(acc);
            if (p) wq.push_back(32'hD0 + 32'(acc));
            #1;
            chk("m_wvalid", m_wvalid, 1'b1);
            chk("d_wready", d_wready, p);
            chk("m_wlast", m_wlast, acc == 3);
            chk("d_rlast_wr", d_rlast, acc == 3);
            if (d_wready === 1'b1) begin
                pulses++;
                if (wq.size() > 0) chk("m_wdata", m_wdata, wq.pop_front());
                else chk("wq_underflow", 64'(wq.size()), 64'd1);
            end
            if (p) acc++;
            tick;
        end
        m_wready = 1'b0;
        d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("wr_pulses", 64'(pulses), 64'd4);
        chk("wr_idle", {m_wvalid, grant}, 3'b000);

        // simultaneous requests, each dropped after its own burst
`ifdef MEM_ARB_RR_EN
        first_i = 1'b1;
`else
        first_i = 1'b0;
`endif
        tick;
        i_req = 1'b1; i_addr = 32'h600;
        d_req = 1'b1; d_addr = 32'h700;
        if (first_i) begin
            wait_addr(2'b01, 32'h600, 1'b0);
            rd_burst(1, 32'h10, -1);
            i_req = 1'b0;
            wait_addr(2'b10, 32'h700, 1'b0);
            rd_burst(2, 32'h20, -1);
            d_req = 1'b0;
        end else begin
            wait_addr(2'b10, 32'h700, 1'b0);
            rd_burst(2, 32'h20, -1);
            d_req = 1'b0;
            wait_addr(2'b01, 32'h600, 1'b0);
            rd_burst(1, 32'h10, -1);
            i_req = 1'b0;
        end

        // early m_rlast on beat 2 of 4
        tick;
        i_req = 1'b1; i_addr = 32'h140;
        wait_addr(2'b01, 32'h140, 1'b0);
        rd_burst(1, 32'h30, 1);
        i_req = 1'b0;
        chk("err_set", err, 1'b1);
        tick; tick;
        #1;
        chk("err_sticky", err, 1'b1);

        // reset in the middle of a read burst
        i_req = 1'b1; i_addr = 32'h180;
        wait_addr(2'b01, 32'h180, 1'b0);
        read_beat(32'h40, 1'b0, 1, 1'b0);
        read_beat(32'h41, 1'b0, 1, 1'b0);
        rstn = 1'b1;
        tick;
        rstn = 1'b0;
        i_req = 1'b0;
        read_beat(32'hEE, 1'b0, 0, 1'b0);
        #1;
        chk("rst_mid_grant", grant, 2'b00);
        chk("rst_mid_err", err, 1'b0);
        chk("rst_mid_m_req", m_req, 1'b0);
        tick;
        i_req = 1'b1; i_addr = 32'h300;
        wait_addr(2'b01, 32'h300, 1'b0);
        rd_burst(1, 32'h50, -1);
        i_req = 1'b0;

        // dcache drops its request mid-refill while an icache request waits
        tick;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        wait_addr(2'b10, 32'h400, 1'b0);
        i_req = 1'b1; i_addr = 32'h500;
        read_beat(32'hB0, 1'b0, 2, 1'b0);
        d_req = 1'b0;
        read_beat(32'hB1, 1'b0, 0, 1'b0);
        read_beat(32'hB2, 1'b0, 0, 1'b0);
        read_beat(32'hB3, 1'b1, 0, 1'b0);
        #1;
        chk("drop_idle_grant", grant, 2'b00);
        wait_addr(2'b01, 32'h500, 1'b0);
        rd_burst(1, 32'hC0, -1);
        i_req = 1'b0;
        chk("final_err", err, 1'b0);
        chk("sb_empty", 64'(rq.size() + wq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester refill arbiter between the instruction cache and the data cache and the single shared memory port. It grants one cache at a time and sequences a full-line burst through the port: an icache read refill, a dcache read refill, or a dcache write-back. It returns or forwards data beat by beat, then releases the port. It sits between the fetch/LSU caches and the memory interface; both caches see it as their only memory.

## Interface
- LINE_WORDS, 4, 32-bit beats per burst (power of two, 2..16)
- ADDR_W, 32, address width
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-high (1 = reset)
- i_req  in  1  icache refill request; held until its last beat
- i_addr  in  ADDR_W  icache line address, line-aligned, stable while i_req
- i_rdata  out  32  refill beat to icache
- i_rvalid  out  1  i_rdata valid
- i_rlast  out  1  final icache beat
- d_req  in  1  dcache request; held until its last beat
- d_we  in  1  1 = write-back, 0 = read refill; stable while d_req
- d_addr  in  ADDR_W  dcache line address, stable while d_req
- d_wdata  in  32  current write-back beat
- d_wready  out  1  d_wdata consumed this cycle; dcache advances
- d_rdata  out  32  refill beat to dcache
- d_rvalid  out  1  d_rdata valid
- d_rlast  out  1  final dcache beat (read or write)
- m_req  out  1  address phase valid
- m_we  out  1  burst direction
- m_addr  out  ADDR_W  burst address
- m_ready  in  1  memory accepts address phase
- m_rdata  in  32  read beat
- m_rvalid  in  1  read beat valid
- m_rlast  in  1  memory's last read beat
- m_wdata  out  32  write beat
- m_wvalid  out  1  write beat valid
- m_wlast  out  1  final write beat
- m_wready  in  1  memory accepts write beat
- grant  out  2  01 = icache, 10 = dcache, 00 = none
- err  out  1  sticky: m_rlast disagreed with the beat count

## Operation
- FSM states: IDLE, ADDR, RDATA, WDATA.
- IDLE: if either request is high, register the winner in grant and go to ADDR.
- ADDR: m_req=1 with the address and m_we of the winner. On m_ready, go to RDATA if m_we=0, else WDATA. The beat counter is cleared.
- RDATA: every m_rvalid increments the counter. The beat is forwarded to the granted side only: i_* or d_*, rdata = m_rdata, rvalid = m_rvalid. At counter == LINE_WORDS-1 with m_rvalid, assert x_rlast and go to IDLE. If m_rlast differs from (counter == LINE_WORDS-1) on any valid beat, set err. The burst length is always LINE_WORDS.
- WDATA: m_wdata = d_wdata and m_wvalid = 1. On m_wready, d_wready=1 and the counter increments. m_wlast and d_rlast are high on beat LINE_WORDS-1; acceptance of that beat returns the FSM to IDLE.
- If a requester drops its request mid-burst, the burst still completes. Read beats for it are suppressed (x_rvalid=0). Write beats continue with whatever d_wdata holds.
- A request arriving for the non-granted side waits. It is sampled only in IDLE.
- grant is 00 in IDLE and holds its value through ADDR/RDATA/WDATA.
- Counter width is log2(LINE_WORDS) and it wraps to 0 on burst end.
- err clears only on reset.

## Timing
- Reset (rstn=1 at an edge): state IDLE, grant=00, counter=0, err=0, round-robin pointer = icache-preferred. All valid/req/ready/last outputs are 0, data outputs are 0.
- A reset mid-burst aborts it immediately. No further beats are forwarded.
- Request high in IDLE at edge N: grant and m_req are valid from N+1.
- Read data path is combinational from m_r* to x_r*, with zero latency.
- Write data path is combinational from d_wdata to m_wdata and from m_wready to d_wready.
- There is one mandatory IDLE cycle between consecutive bursts.
- Minimum read burst is 1 (IDLE) + 1 (ADDR) + LINE_WORDS cycles.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a simultaneous request, the side not granted last wins.
  - The pointer updates at each grant.
  - A single request always wins.
- MEM_ARB_RR_EN undefined: fixed priority. dcache always wins a simultaneous request and there is no pointer state.

## Test plan
- Icache read: i_req=1, i_addr=0x100, m_ready at the first ADDR cycle, 4 beats 0xA0..0xA3 with rlast on the 4th.
  - Expected: grant=01 at N+1, i_rvalid four times with the same data, i_rlast on 0xA3, back to IDLE, err=0.
- Dcache write-back: d_we=1, d_addr=0x200, m_wready toggling 1,0,1,1,1.
  - Expected: exactly 4 d_wready pulses, m_wlast on the 4th accepted beat, d_rlast coincident with it.
- Simultaneous i_req and d_req held for two bursts.
  - Expected with MEM_ARB_RR_EN: grant order 01 then 10.
  - Expected without it: order 10 then 01.
- Protocol mismatch: m_rlast=1 on beat 2 of 4.
  - Expected: err=1 and sticky. The burst still ends after beat 4.
- Reset during RDATA after 2 beats.
  - Expected: next cycle state IDLE, grant=00, no x_rvalid for late m_rvalid. A new i_req is served normally.
- Requester drop: d_req falls during a dcache read.
  - Expected: remaining beats are consumed with d_rvalid=0. A pending i_req is granted after the IDLE cycle.
